pwm_deadtime: RTL and testbench
===============================

PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 SHALL have parameter AddressWidth, default 2, meaning channel count N = 2**AddressWidth (matches the PWM generator output width).
REQ-002 SHALL have parameter DeadWidth, default 4, meaning the width of the dead-time count in pwmclk cycles.
REQ-003 SHALL have port pwmclk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  global enable for the output drivers.
REQ-006 SHALL have port dead  input  DeadWidth  dead-time length in pwmclk cycles.
REQ-007 SHALL have port I  input  N  per-channel PWM command, directly from the PWM generator outputs.
REQ-008 SHALL have port H  output  N  high-side drive per channel.
REQ-009 SHALL have port L  output  N  low-side drive per channel.
REQ-010 SHALL have port busy  output  N  per channel, 1 while that channel is in a dead interval.

Function
REQ-011 SHALL register I into Ireg on every pwmclk edge; all per-channel decisions use Ireg only.
REQ-012 SHALL run one independent FSM per channel, with states DIS (H=0,L=0), OFF (H=0,L=1), DR (dead-rise, H=0,L=0), ON (H=1,L=0) and DF (dead-fall, H=0,L=0).
REQ-013 SHALL decode H, L and busy from registered state only (Moore); no combinational path from I, en or dead to any output.
REQ-014 SHALL never assert H[i] and L[i] together, in any state, at any time.
REQ-015 SHALL, when en=0, move every channel to DIS at the next edge; this has priority over all other transitions.
REQ-016 SHALL move DIS to OFF when en=1, regardless of Ireg.
REQ-017 SHALL handle OFF with Ireg=1 as follows: dead=0 -> ON; otherwise -> DR, loading the counter with dead.
REQ-018 SHALL handle ON with Ireg=0 as follows: dead=0 -> OFF; otherwise -> DF, loading the counter with dead.
REQ-019 SHALL, in DR/DF, decrement the counter each edge; on the edge where counter==1, DR -> ON and DF -> OFF, so each dead interval lasts exactly dead cycles.
REQ-020 SHALL abort a dead interval on a command reversal: DR with Ireg=0 -> OFF, and DF with Ireg=1 -> ON, at the next edge.
REQ-021 SHALL sample dead only when entering DR/DF; changes to dead during an interval have no effect on it.
REQ-022 SHALL give, with dead=D>0, a latency from an I edge captured at edge k of: active-side release at edge k+1, opposite-side assert at edge k+1+D.

Reset
REQ-023 SHALL, while rst=1, force every channel to DIS, Ireg=0 and counters=0: H=0, L=0, busy=0 for all channels.
REQ-024 SHALL, on rst release, leave channels in DIS until the first edge with en=1.
REQ-025 SHALL, on rst assertion mid-dead-interval or mid-ON, deassert H immediately (asynchronously).

Configuration
REQ-026 SHALL support macro PWM_DEADTIME_FAULT_EN; when it is defined, the block adds input fault (1 bit) and output faulted (1 bit).
REQ-027 SHALL, with PWM_DEADTIME_FAULT_EN defined: fault is sampled at pwmclk; fault=1 sets faulted=1 (sticky, cleared only by rst) and forces all channels to DIS at the next edge.
REQ-028 SHALL, with PWM_DEADTIME_FAULT_EN defined, hold all channels in DIS while faulted=1, regardless of en or I; faulted resets to 0.
REQ-029 SHALL, without PWM_DEADTIME_FAULT_EN, omit the fault and faulted ports; behaviour is otherwise identical.

Verification (AddressWidth=2, DeadWidth=4)
REQ-030 SHALL cover reset: rst=1 -> H=0000, L=0000, busy=0000; after release with en=1, I=0000 -> L=1111 one edge later.
REQ-031 SHALL cover dead=3, I[0] 0->1 captured at edge k: L[0]=0 at k+1, H[0]=1 at k+4, busy[0]=1 for exactly 3 cycles; the 1->0 transition is symmetric.
REQ-032 SHALL cover dead=0: I[2] toggling gives H/L swapping on the same edge, never both 0, busy[2] never 1.
REQ-033 SHALL cover abort: dead=5 with a 2-cycle pulse on I[1] -> L[1] low for 2 cycles then high, H[1] never 1; dead changed to 1 mid-interval has no effect.
REQ-034 SHALL cover enable drop: en=0 while channel 3 is ON -> H[3]=L[3]=0 next edge; en=1 -> OFF (L[3]=1) next edge, then DR if I[3]=1.
REQ-035 SHALL cover fault (macro defined): fault pulse while ON -> all H,L=0 next edge, faulted=1, held through fault=0 and an en toggle; cleared only by rst.

Source files
------------

// File: rtl/pwm_deadtime.sv
// pwm_deadtime -- complementary high/low-side driver with dead-time insertion.
//
// Each PWM command bit I[i] is registered into Ireg[i] and drives an
// independent five-state Moore FSM (DIS, OFF, DR, ON, DF). Outputs are
// decoded from the registered state only, so H[i] and L[i] are never both
// high and no input has a combinational path to an output.
//
// Optional feature: define PWM_DEADTIME_FAULT_EN to add a sticky fault latch
// (ports fault/faulted) that holds every channel disabled until rst.
//
// Parameters:
//   AddressWidth  channel count N = 2**AddressWidth
//   DeadWidth     width of the dead-time count (pwmclk cycles)
// Ports:
//   pwmclk        clock, rising edge
//   rst           asynchronous active-high reset
//   en            global enable for the output drivers
//   dead          dead-time length, sampled when a dead interval starts
//   I[N]          per-channel PWM command
//   H[N], L[N]    high-side / low-side drives
//   busy[N]       channel is inside a dead interval
//   fault         (PWM_DEADTIME_FAULT_EN) fault request, sampled at pwmclk
//   faulted       (PWM_DEADTIME_FAULT_EN) sticky fault flag

// Per-channel dead-time FSM.
module pwm_deadtime_ch #(
   parameter int DeadWidth = 4
) (
   input  logic                 pwmclk,
   input  logic                 rst,
   input  logic                 kill,
   input  logic                 ireg,
   input  logic [DeadWidth-1:0] dead,
   output logic                 h,
   output logic                 l,
   output logic                 busy
);

   typedef enum logic [2:0] {
      DIS = 3'd0,
      OFF = 3'd1,
      DR  = 3'd2,
      ON  = 3'd3,
      DF  = 3'd4
   } state_t;

   state_t               state, state_nxt;
   logic [DeadWidth-1:0] cnt, cnt_nxt;

   // Async reset drops H immediately, since H is a decode of state.
   always_ff @(posedge pwmclk or posedge rst) begin
      if (rst) begin
         state <= DIS;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      h         = 1'b0;
      l         = 1'b0;
      busy      = 1'b0;

      case (state)
         OFF:     l    = 1'b1;
         ON:      h    = 1'b1;
         DR, DF:  busy = 1'b1;
         default: ;
      endcase

      if (kill) begin
         state_nxt = DIS;
         cnt_nxt   = '0;
      end else begin
         case (state)
            DIS: state_nxt = OFF;
            OFF: begin
               if (ireg) begin
                  if (dead == '0) begin
                     state_nxt = ON;
                  end else begin
                     state_nxt = DR;
                     cnt_nxt   = dead;
                  end
               end
            end
            ON: begin
               if (!ireg) begin
                  if (dead == '0) begin
                     state_nxt = OFF;
                  end else begin
                     state_nxt = DF;
                     cnt_nxt   = dead;
                  end
               end
            end
            // Command reversal aborts the interval back to the side we left.
            // Otherwise cnt counts down; leaving on cnt==1 makes the interval
            // exactly the loaded number of cycles.
            DR: begin
               if (!ireg) begin
                  state_nxt = OFF;
                  cnt_nxt   = '0;
               end else if (cnt == DeadWidth'(1)) begin
                  state_nxt = ON;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - DeadWidth'(1);
               end
            end
            DF: begin
               if (ireg) begin
                  state_nxt = ON;
                  cnt_nxt   = '0;
               end else if (cnt == DeadWidth'(1)) begin
                  state_nxt = OFF;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - DeadWidth'(1);
               end
            end
            default: begin
               state_nxt = DIS;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

endmodule

// Top: command register, global kill and the channel array.
module pwm_deadtime #(
   parameter int AddressWidth = 2,
   parameter int DeadWidth    = 4
) (
   input  logic                         pwmclk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [DeadWidth-1:0]         dead,
   input  logic [(2**AddressWidth)-1:0] I,
   output logic [(2**AddressWidth)-1:0] H,
   output logic [(2**AddressWidth)-1:0] L,
   output logic [(2**AddressWidth)-1:0] busy
`ifdef PWM_DEADTIME_FAULT_EN
   ,
   input  logic                         fault,
   output logic                         faulted
`endif
);

   localparam int N = 2**AddressWidth;

   logic [N-1:0] Ireg;
   logic         kill;

   always_ff @(posedge pwmclk or posedge rst) begin
      if (rst) Ireg <= '0;
      else     Ireg <= I;
   end

`ifdef PWM_DEADTIME_FAULT_EN
   // A fault takes effect on the same edge it is sampled, then latches.
   always_ff @(posedge pwmclk or posedge rst) begin
      if (rst)        faulted <= 1'b0;
      else if (fault) faulted <= 1'b1;
   end

   assign kill = !en || fault || faulted;
`else
   assign kill = !en;
`endif

   for (genvar i = 0; i < N; i++) begin : g_ch
      pwm_deadtime_ch #(
         .DeadWidth (DeadWidth)
      ) u_ch (
         .pwmclk (pwmclk),
         .rst    (rst),
         .kill   (kill),
         .ireg   (Ireg[i]),
         .dead   (dead),
         .h      (H[i]),
         .l      (L[i]),
         .busy   (busy[i])
      );
   end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime (AddressWidth=2, DeadWidth=4).
// The driver applies one directed vector per cycle on the falling edge and
// pushes the hand-computed outputs expected after the next rising edge; the
// monitor pops and compares just after every rising edge.
module tb_pwm_deadtime;

   logic       pwmclk = 1'b0;
   logic       rst    = 1'b1;
   logic       en     = 1'b0;
   logic [3:0] dead   = '0;
   logic [3:0] I      = '0;
   logic [3:0] H, L, busy;
   logic       fault  = 1'b0;
   logic       faulted_w;

   typedef struct {
      logic [3:0] h, l, b;
      logic       f;
      int         id;
   } exp_t;

   exp_t q[$];
   int   total  = 0;
   int   passed = 0;
   int   rowid  = 0;

   always #5 pwmclk = ~pwmclk;

`ifdef PWM_DEADTIME_FAULT_EN
   pwm_deadtime dut (
      .pwmclk (pwmclk), .rst (rst), .en (en), .dead (dead), .I (I),
      .H (H), .L (L), .busy (busy), .fault (fault), .faulted (faulted_w)
   );
`else
   pwm_deadtime dut (
      .pwmclk (pwmclk), .rst (rst), .en (en), .dead (dead), .I (I),
      .H (H), .L (L), .busy (busy)
   );
   assign faulted_w = 1'b0;
`endif

   // Monitor
   always @(posedge pwmclk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         if (H === e.h && L === e.l && busy === e.b && faulted_w === e.f)
            passed++;
         else
            $display("FAIL row%0d: got H=%b L=%b busy=%b faulted=%b want H=%b L=%b busy=%b faulted=%b",
                     e.id, H, L, busy, faulted_w, e.h, e.l, e.b, e.f);
      end
   end

   task automatic drive(input logic r, input logic e, input logic fl,
                        input logic [3:0] d, input logic [3:0] i,
                        input logic [3:0] eh, input logic [3:0] el,
                        input logic [3:0] eb, input logic ef);
      exp_t x;
      @(negedge pwmclk);
      rst = r; en = e; fault = fl; dead = d; I = i;
      rowid++;
      x.h = eh; x.l = el; x.b = eb; x.f = ef; x.id = rowid;
      q.push_back(x);
   endtask

   task automatic check_now(input string name, input logic [3:0] eh,
                            input logic [3:0] el, input logic [3:0] eb);
      total++;
      if (H === eh && L === el && busy === eb) passed++;
      else $display("FAIL %s: got H=%b L=%b busy=%b want H=%b L=%b busy=%b",
                    name, H, L, busy, eh, el, eb);
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() > 0 && n < 20) begin
         @(posedge pwmclk);
         n++;
      end
      #2;
      if (q.size() > 0) begin
         total++;
         $display("FAIL drain: got %0d pending want 0", q.size());
         q.delete();
      end
   endtask

   initial begin
      #2 check_now("reset_async", 4'b0000, 4'b0000, 4'b0000);
      //     rst en flt dead  I        H        L        busy   f
      drive(1, 0, 0, 4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
      drive(1, 1, 0, 4'd3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
      // release, enable: DIS -> OFF
      drive(0, 1, 0, 4'd3, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      // dead=3 rise on ch0, captured at k
      drive(0, 1, 0, 4'd3, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd3, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 0);
      drive(0, 1, 0, 4'd3, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 0);
      drive(0, 1, 0, 4'd3, 4'b0001, 4'b0000, 4'b1110, 4'b0001, 0);
      drive(0, 1, 0, 4'd3, 4'b0001, 4'b0001, 4'b1110, 4'b0000, 0);
      // symmetric fall
      drive(0, 1, 0, 4'd3, 4'b0000, 4'b0001, 4'b1110, 4'b0000, 0);
      drive(0, 1, 0, 4'd3, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 0);
      drive(0, 1, 0, 4'd3, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 0);
      drive(0, 1, 0, 4'd3, 4'b0000, 4'b0000, 4'b1110, 4'b0001, 0);
      drive(0, 1, 0, 4'd3, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      // dead=0 on ch2: swap on the same edge
      drive(0, 1, 0, 4'd0, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0000, 4'b0100, 4'b1011, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0100, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0000, 4'b0100, 4'b1011, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      // abort: dead=5, 2-cycle pulse on ch1, dead changed to 1 mid-interval
      drive(0, 1, 0, 4'd5, 4'b0010, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd5, 4'b0010, 4'b0000, 4'b1101, 4'b0010, 0);
      drive(0, 1, 0, 4'd1, 4'b0000, 4'b0000, 4'b1101, 4'b0010, 0);
      drive(0, 1, 0, 4'd1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd1, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      // dead sampled on entry only: 3 loaded, then dead=1 during interval
      drive(0, 1, 0, 4'd1, 4'b0010, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd3, 4'b0010, 4'b0000, 4'b1101, 4'b0010, 0);
      drive(0, 1, 0, 4'd1, 4'b0010, 4'b0000, 4'b1101, 4'b0010, 0);
      drive(0, 1, 0, 4'd1, 4'b0010, 4'b0000, 4'b1101, 4'b0010, 0);
      drive(0, 1, 0, 4'd1, 4'b0010, 4'b0010, 4'b1101, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0000, 4'b0010, 4'b1101, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      // enable drop with ch3 ON
      drive(0, 1, 0, 4'd0, 4'b1000, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b1000, 4'b1000, 4'b0111, 4'b0000, 0);
      drive(0, 0, 0, 4'd0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0);
      drive(0, 1, 0, 4'd2, 4'b1000, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd2, 4'b1000, 4'b0000, 4'b0111, 4'b1000, 0);
      drive(0, 1, 0, 4'd2, 4'b1000, 4'b0000, 4'b0111, 4'b1000, 0);
      drive(0, 1, 0, 4'd2, 4'b1000, 4'b1000, 4'b0111, 4'b0000, 0);
      // DF aborted by reversal back to ON
      drive(0, 1, 0, 4'd2, 4'b0000, 4'b1000, 4'b0111, 4'b0000, 0);
      drive(0, 1, 0, 4'd2, 4'b1000, 4'b0000, 4'b0111, 4'b1000, 0);
      drive(0, 1, 0, 4'd2, 4'b1000, 4'b1000, 4'b0111, 4'b0000, 0);
      drain();
      // reset mid-ON drops H without waiting for a clock edge
      @(negedge pwmclk);
      #2 rst = 1'b1;
      #1 check_now("reset_mid_on", 4'b0000, 4'b0000, 4'b0000);
      drive(1, 1, 0, 4'd2, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0);
`ifdef PWM_DEADTIME_FAULT_EN
      drive(0, 1, 0, 4'd0, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0001, 4'b0001, 4'b1110, 4'b0000, 0);
      drive(0, 1, 1, 4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
      drive(0, 1, 0, 4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
      drive(0, 0, 0, 4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
      drive(0, 1, 0, 4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
      drive(0, 1, 0, 4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
      drive(1, 1, 0, 4'd0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
      drive(0, 1, 0, 4'd0, 4'b0001, 4'b0000, 4'b1111, 4'b0000, 0);
`endif
      drive(0, 1, 0, 4'd0, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0);
      drain();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
